// File: rtl/seq_matrix_pkg.sv
// seq_matrix_pkg: shared geometry, scan states and LED index mapping for the 4x4 matrices
package seq_matrix_pkg;
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  typedef logic [3:0] led_idx_t;
  typedef enum logic {BLANK, DRIVE} scan_state_t;
  function automatic led_idx_t idx(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction
endpackage

// File: rtl/matrix_scan_timer.sv
// matrix_scan_timer: per-row BLANK/DRIVE sequencer with row and phase counters
//   clk, rst     clock, async active-high reset
//   state, row   current scan phase and row
//   row_start    first DRIVE cycle of a row
//   frame_start  first BLANK cycle of row 0
module matrix_scan_timer import seq_matrix_pkg::*; #(
  parameter int DEAD_CYCLES = 16,
  parameter int ROW_CYCLES  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  output scan_state_t state,
  output logic [1:0]  row,
  output logic        row_start,
  output logic        frame_start
);
  localparam int CW = $clog2(ROW_CYCLES + DEAD_CYCLES);
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);
  localparam logic [CW-1:0] ROW_LAST  = CW'(ROW_CYCLES - 1);
  scan_state_t state_q, state_d;
  logic [1:0] row_q, row_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    state_d = state_q;
    row_d = row_q;
    cnt_d = cnt_q + 1'b1;
    if (state_q == BLANK && cnt_q == DEAD_LAST) begin
      state_d = DRIVE;
      cnt_d = '0;
    end
    if (state_q == DRIVE && cnt_q == ROW_LAST) begin
      state_d = BLANK;
      cnt_d = '0;
      row_d = row_q + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BLANK;
      row_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      cnt_q <= cnt_d;
    end
  end
  assign state = state_q;
  assign row = row_q;
  assign row_start = state_q == DRIVE && cnt_q == '0;
  assign frame_start = state_q == BLANK && row_q == 2'd0 && cnt_q == '0;
endmodule

// File: rtl/led_matrix_driver.sv
// led_matrix_driver: row-multiplexed 4x4 LED driver with tear-free pattern swap, PWM and cursor
//   pattern_in/valid/ready  16-bit pattern handshake into a one-deep pending slot
//   brightness, cursor_*    global PWM duty and full-brightness playhead LED
//   row_outputs             one-hot-low row select, col_outputs active-high columns
//   frame_start             pulse on the first blank cycle of row 0
module led_matrix_driver import seq_matrix_pkg::*; #(
  parameter int ROW_CYCLES  = 1024,
  parameter int DEAD_CYCLES = 16,
  parameter int PWM_BITS    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         pattern_in,
  input  logic                pattern_valid,
  output logic                pattern_ready,
  input  logic [PWM_BITS-1:0] brightness,
  input  logic                cursor_en,
  input  logic [3:0]          cursor_index,
  output logic [3:0]          row_outputs,
  output logic [3:0]          col_outputs,
  output logic                frame_start
);
  scan_state_t state;
  logic [1:0] row;
  logic row_start, scan_frame_start;
  logic [15:0] act_q, act_d, pend_q, pend_d;
  logic pend_full_q, pend_full_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d, pwm;
  logic [3:0] row_out_q, row_out_d, col_out_q, col_out_d;
  logic frame_start_q, frame_start_d;
  matrix_scan_timer #(.DEAD_CYCLES(DEAD_CYCLES), .ROW_CYCLES(ROW_CYCLES)) u_timer (
    .clk(clk),
    .rst(rst),
    .state(state),
    .row(row),
    .row_start(row_start),
    .frame_start(scan_frame_start)
  );
  assign pattern_ready = !pend_full_q;
  // columns read act_d so a swap on the frame_start cycle is visible even with one dead cycle
  always_comb begin
    act_d = (frame_start_q && pend_full_q) ? pend_q : act_q;
    pend_d = (pattern_valid && !pend_full_q) ? pattern_in : pend_q;
    pend_full_d = (pattern_valid && !pend_full_q) || (pend_full_q && !frame_start_q);
    pwm = row_start ? '0 : pwm_q;
    pwm_d = pwm + 1'b1;
    col_out_d = '0;
    for (int c = 0; c < NUM_COLS; c++)
      col_out_d[c] = state == DRIVE &&
        ((act_d[idx(row, 2'(c))] && pwm < brightness) || (cursor_en && cursor_index == idx(row, 2'(c))));
    row_out_d = state == DRIVE ? ~(4'b0001 << row) : 4'b1111;
    frame_start_d = scan_frame_start;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_q <= '0;
      pend_q <= '0;
      pend_full_q <= 1'b0;
      pwm_q <= '0;
      row_out_q <= 4'b1111;
      col_out_q <= '0;
      frame_start_q <= 1'b0;
    end else begin
      act_q <= act_d;
      pend_q <= pend_d;
      pend_full_q <= pend_full_d;
      pwm_q <= pwm_d;
      row_out_q <= row_out_d;
      col_out_q <= col_out_d;
      frame_start_q <= frame_start_d;
    end
  end
  assign row_outputs = row_out_q;
  assign col_outputs = col_out_q;
  assign frame_start = frame_start_q;
endmodule

// File: tb/tb_led_matrix_driver.sv
// tb_led_matrix_driver: scenario tasks with a pattern scoreboard against the matrix driver
module tb_led_matrix_driver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] pattern_in = '0;
  logic pattern_valid = 1'b0;
  logic pattern_ready;
  logic [1:0] brightness = '0;
  logic cursor_en = 1'b0;
  logic [3:0] cursor_index = '0;
  logic [3:0] row_outputs, col_outputs;
  logic frame_start;
  int checks = 0;
  int failures = 0;
  int led_cnt[16];
  int bad_cnt;
  logic [15:0] exp_q[$];
  logic [15:0] exp_p;

  led_matrix_driver #(.ROW_CYCLES(16), .DEAD_CYCLES(2), .PWM_BITS(2)) dut (
    .clk(clk),
    .rst(rst),
    .pattern_in(pattern_in),
    .pattern_valid(pattern_valid),
    .pattern_ready(pattern_ready),
    .brightness(brightness),
    .cursor_en(cursor_en),
    .cursor_index(cursor_index),
    .row_outputs(row_outputs),
    .col_outputs(col_outputs),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  function automatic int exp_cnt(logic [15:0] p, int b, bit ce, int ci, int i);
    if (ce && ci == i) return 16;
    return p[i] ? 4 * b : 0;
  endfunction

  task automatic send(input logic [15:0] p);
    pattern_in = p;
    pattern_valid = 1'b1;
    @(negedge clk);
    pattern_valid = 1'b0;
  endtask

  task automatic wait_fs();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_start !== 1'b1 && n < 200);
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL wait_fs: frame_start not seen within %0d cycles", n);
    end
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < 16; i++) led_cnt[i] = 0;
    bad_cnt = 0;
    for (int k = 0; k < n; k++) begin
      if (row_outputs == 4'b1111) begin
        if (col_outputs != 4'b0000) bad_cnt++;
      end else if ($countones(~row_outputs) != 1) bad_cnt++;
      else
        for (int r = 0; r < 4; r++)
          if (!row_outputs[r])
            for (int c = 0; c < 4; c++)
              if (col_outputs[c]) led_cnt[r * 4 + c]++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int n;
    brightness = 2'd0;
    cursor_en = 1'b1;
    cursor_index = 4'd0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (frame_start !== 1'b1) begin failures++; $display("FAIL fs_first: got %b want 1", frame_start); end
    send(16'h1234);
    n = 0;
    while (row_outputs !== 4'b1110 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (col_outputs !== 4'b0001 || pattern_ready !== 1'b0) begin
      failures++;
      $display("FAIL pre_reset: cols=%b ready=%b want 0001/0", col_outputs, pattern_ready);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (row_outputs !== 4'b1111) begin failures++; $display("FAIL rst_rows: got %b want 1111", row_outputs); end
    checks++;
    if (col_outputs !== 4'b0000) begin failures++; $display("FAIL rst_cols: got %b want 0000", col_outputs); end
    checks++;
    if (pattern_ready !== 1'b1) begin failures++; $display("FAIL rst_ready: got %b want 1", pattern_ready); end
    checks++;
    if (frame_start !== 1'b0) begin failures++; $display("FAIL rst_fs: got %b want 0", frame_start); end
    brightness = 2'd3;
    cursor_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (frame_start !== 1'b1) begin failures++; $display("FAIL fs_cycle1: got %b want 1", frame_start); end
    n = 0;
    do begin @(negedge clk); n++; end while (frame_start !== 1'b1 && n < 200);
    checks++;
    if (n != 72) begin failures++; $display("FAIL frame_period: got %0d want 72", n); end
    capture(72);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (led_cnt[i] != 0) begin failures++; $display("FAIL discard led%0d: got %0d want 0", i, led_cnt[i]); end
    end
  endtask

  task automatic test_single_led();
    int err = 0;
    checks++;
    if (pattern_ready !== 1'b1) begin failures++; $display("FAIL t2_ready_fs: got %b want 1", pattern_ready); end
    exp_q.push_back(16'h0001);
    send(16'h0001);
    checks++;
    if (pattern_ready !== 1'b0) begin failures++; $display("FAIL t2_ready_low: got %b want 0", pattern_ready); end
    while (frame_start !== 1'b1 && err < 1000) begin
      if (pattern_ready !== 1'b0) err++;
      @(negedge clk);
      if (frame_start !== 1'b1 && row_outputs == 4'b1111 && col_outputs == 4'b0000 && err == 0 && $time > 100000) err = 1000;
    end
    checks++;
    if (err != 0) begin failures++; $display("FAIL t2_ready_hold: %0d cycles ready high, want 0", err); end
    checks++;
    if (pattern_ready !== 1'b0) begin failures++; $display("FAIL t2_ready_at_fs: got %b want 0", pattern_ready); end
    @(negedge clk);
    checks++;
    if (pattern_ready !== 1'b1) begin failures++; $display("FAIL t2_ready_after: got %b want 1", pattern_ready); end
    capture(71);
    exp_p = exp_q.pop_front();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (led_cnt[i] != exp_cnt(exp_p, 3, 0, 0, i)) begin
        failures++;
        $display("FAIL t2 led%0d: got %0d want %0d", i, led_cnt[i], exp_cnt(exp_p, 3, 0, 0, i));
      end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    exp_q.push_back(16'hAAAA);
    pattern_in = 16'hAAAA;
    pattern_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (pattern_ready !== 1'b0) begin failures++; $display("FAIL t3_ready_2nd: got %b want 0", pattern_ready); end
    send(16'h5555);
    wait_fs();
    capture(72);
    exp_p = exp_q.pop_front();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (led_cnt[i] != exp_cnt(exp_p, 3, 0, 0, i)) begin
        failures++;
        $display("FAIL t3 led%0d: got %0d want %0d", i, led_cnt[i], exp_cnt(exp_p, 3, 0, 0, i));
      end
    end
    checks++;
    if (pattern_ready !== 1'b1) begin failures++; $display("FAIL t3_ready_end: got %b want 1", pattern_ready); end
  endtask

  task automatic test_cursor();
    @(negedge clk);
    exp_q.push_back(16'h0000);
    send(16'h0000);
    brightness = 2'd0;
    cursor_en = 1'b1;
    cursor_index = 4'd10;
    wait_fs();
    capture(72);
    exp_p = exp_q.pop_front();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (led_cnt[i] != exp_cnt(exp_p, 0, 1, 10, i)) begin
        failures++;
        $display("FAIL t4 led%0d: got %0d want %0d", i, led_cnt[i], exp_cnt(exp_p, 0, 1, 10, i));
      end
    end
  endtask

  task automatic test_full_dim();
    @(negedge clk);
    exp_q.push_back(16'hFFFF);
    send(16'hFFFF);
    brightness = 2'd1;
    cursor_en = 1'b0;
    wait_fs();
    capture(72);
    exp_p = exp_q.pop_front();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (led_cnt[i] != exp_cnt(exp_p, 1, 0, 0, i)) begin
        failures++;
        $display("FAIL t5 led%0d: got %0d want %0d", i, led_cnt[i], exp_cnt(exp_p, 1, 0, 0, i));
      end
    end
    checks++;
    if (bad_cnt != 0) begin failures++; $display("FAIL t5_blank_onehot: %0d bad cycles, want 0", bad_cnt); end
  endtask

  task automatic test_streaming();
    bit started = 0;
    bit mfull = 0;
    int xfers = 0;
    int rdy_err = 0;
    int frames = 0;
    logic [15:0] mask = '0;
    logic [15:0] d = 16'h0100;
    exp_q.delete();
    brightness = 2'd3;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (frame_start === 1'b1) begin
        if (started) begin
          frames++;
          exp_p = exp_q.pop_front();
          checks++;
          if (mask !== exp_p) begin failures++; $display("FAIL t6_frame%0d: shown %h want %h", frames, mask, exp_p); end
          checks++;
          if (xfers != 1) begin failures++; $display("FAIL t6_xfers%0d: got %0d want 1", frames, xfers); end
        end
        started = 1;
        mask = '0;
        xfers = 0;
      end
      if (started && row_outputs != 4'b1111 && $countones(~row_outputs) == 1)
        for (int r = 0; r < 4; r++)
          if (!row_outputs[r]) mask = mask | ({12'b0, col_outputs} << (4 * r));
      pattern_valid = 1'b1;
      pattern_in = d;
      d = d + 16'd1;
      if (pattern_ready !== !mfull) rdy_err++;
      if (pattern_ready === 1'b1) xfers++;
      if (!mfull) begin
        exp_q.push_back(pattern_in);
        mfull = 1;
      end else if (frame_start === 1'b1) mfull = 0;
    end
    pattern_valid = 1'b0;
    checks++;
    if (rdy_err != 0) begin failures++; $display("FAIL t6_ready: %0d cycles wrong, want 0", rdy_err); end
    checks++;
    if (frames < 3) begin failures++; $display("FAIL t6_frames: got %0d want >=3", frames); end
  endtask

  initial begin
    test_reset();
    test_single_led();
    test_back_to_back();
    test_cursor();
    test_full_dim();
    test_streaming();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
